// File: rtl/bitnet_pkg.sv
// Shared op-stream definitions for the bitnet op fetch path.
// HALT opcode, fetch FSM state encoding and the op word type.
package bitnet_pkg;

    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef logic [7:0] op_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/op_fetch_fifo.sv
// Small synchronous FIFO holding {pc, op} pairs between the BRAM tap and the consumer.
// Head is read from the storage registers (no write-through bypass); flush empties it in one cycle.
module op_fetch_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             wr_en_in,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic             rd_en_in,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             empty_out,
    output logic [CW-1:0]    count_out
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_rd = rd_en_in & (r_count != CW'(0));
    assign w_wr = wr_en_in & ((r_count != CW'(DEPTH)) | w_rd);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data_in;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data_out = r_mem[r_rd_ptr];
    assign empty_out   = (r_count == CW'(0));
    assign count_out   = r_count;

endmodule

// File: rtl/op_fetch_unit.sv
// Op BRAM port-B reader: streams ops from a start address to the execution engine until HALT or abort.
// Optional OP_FETCH_COUNT_EN adds op_count_out, a saturating count of accepted transfers.
module op_fetch_unit
    import bitnet_pkg::*;
#(
    parameter int OP_DEPTH      = 1024,
    parameter int OP_BRAM_WIDTH = 8,
    parameter int BRAM_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int AW           = $clog2(OP_DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [AW-1:0]            start_addr_in,
    input  logic                     abort_in,
    output logic [AW-1:0]            bram_addr_out,
    input  logic [OP_BRAM_WIDTH-1:0] bram_data_in,
    output logic [OP_BRAM_WIDTH-1:0] op_out,
    output logic [AW-1:0]            op_pc_out,
    output logic                     op_valid_out,
    input  logic                     op_ready_in,
`ifdef OP_FETCH_COUNT_EN
    output logic [15:0]              op_count_out,
`endif
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int FW = OP_BRAM_WIDTH + AW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(FIFO_DEPTH + BRAM_LATENCY) + 1;
    localparam logic [AW-1:0] PC_LAST = AW'(OP_DEPTH - 1);

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [AW-1:0]        r_pc;
    logic [AW-1:0]        r_addr_hold;
    logic [BRAM_LATENCY-1:0] r_pipe_v;
    logic [AW-1:0]        r_pipe_pc [BRAM_LATENCY];
    logic [SW-1:0]        w_inflight;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_empty;
    logic [FW-1:0]        w_fifo_head;
    logic                 w_start_acc;
    logic                 w_tap_v;
    logic                 w_tap_halt;
    logic                 w_enq;
    logic                 w_issue;
    logic                 w_xfer;
    logic                 w_flush;

    assign w_start_acc = (r_state == ST_IDLE) & start_in & ~abort_in;
    assign w_tap_v     = r_pipe_v[BRAM_LATENCY-1];
    assign w_tap_halt  = w_tap_v & (r_state == ST_RUN) & (bram_data_in == OP_BRAM_WIDTH'(OP_HALT));
    assign w_enq       = w_tap_v & (r_state == ST_RUN) & ~w_tap_halt & ~abort_in;
    assign w_flush     = abort_in & (r_state != ST_IDLE);
    assign w_xfer      = ~w_fifo_empty & op_ready_in;

    // Credits: every issued read already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_pipe_v[i]);
        end
        if ((r_state == ST_RUN) && !abort_in && !w_tap_halt &&
            ((SW'(w_fifo_count) + w_inflight) < SW'(FIFO_DEPTH))) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_in) begin
                    w_state_next = ST_IDLE;
                end else if (w_tap_halt) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort_in || w_fifo_empty) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, program counter and in-flight read tags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_addr_hold <= '0;
            r_pipe_v    <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                r_pipe_pc[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_start_acc) begin
                r_pc <= start_addr_in;
            end else if (w_issue) begin
                r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + AW'(1);
            end
            if (w_issue) begin
                r_addr_hold <= r_pc;
            end
            // Abort and HALT both kill whatever reads are still in flight.
            if (abort_in || w_tap_halt) begin
                r_pipe_v <= '0;
            end else begin
                r_pipe_v <= {r_pipe_v[BRAM_LATENCY-2:0], w_issue};
            end
            r_pipe_pc[0] <= r_pc;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                r_pipe_pc[i] <= r_pipe_pc[i-1];
            end
        end
    end

    op_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (w_flush),
        .wr_en_in    (w_enq),
        .wr_data_in  ({r_pipe_pc[BRAM_LATENCY-1], bram_data_in}),
        .rd_en_in    (w_xfer),
        .rd_data_out (w_fifo_head),
        .empty_out   (w_fifo_empty),
        .count_out   (w_fifo_count)
    );

    assign bram_addr_out = w_issue ? r_pc : r_addr_hold;
    assign op_out        = w_fifo_head[OP_BRAM_WIDTH-1:0];
    assign op_pc_out     = w_fifo_head[FW-1:OP_BRAM_WIDTH];
    assign op_valid_out  = ~w_fifo_empty;
    assign busy_out      = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign done_out      = (r_state == ST_DRAIN) & w_fifo_empty & ~abort_in;

`ifdef OP_FETCH_COUNT_EN
    logic [15:0] r_op_count;

    // Accepted-transfer counter, restarted by each accepted start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_op_count <= 16'd0;
        end else if (w_start_acc) begin
            r_op_count <= 16'd0;
        end else if (w_xfer && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count_out = r_op_count;
`endif

endmodule

// File: tb/tb_op_fetch_unit.sv
// Self-checking bench for op_fetch_unit: BRAM model with 2-cycle latency and a program-walk reference.
// Build with +define+OP_FETCH_COUNT_EN to also check the transfer counter.
module tb_op_fetch_unit;

    localparam int DEPTH = 1024;
    localparam int MAXC  = 600;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic [9:0] start_addr_in;
    logic       abort_in;
    logic [9:0] bram_addr_out;
    logic [7:0] bram_data_in;
    logic [7:0] op_out;
    logic [9:0] op_pc_out;
    logic       op_valid_out;
    logic       op_ready_in;
    logic       busy_out;
    logic       done_out;
`ifdef OP_FETCH_COUNT_EN
    logic [15:0] op_count_out;
`endif

    always #5 clk_in = ~clk_in;

    op_fetch_unit dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .start_addr_in (start_addr_in),
        .abort_in      (abort_in),
        .bram_addr_out (bram_addr_out),
        .bram_data_in  (bram_data_in),
        .op_out        (op_out),
        .op_pc_out     (op_pc_out),
        .op_valid_out  (op_valid_out),
        .op_ready_in   (op_ready_in),
`ifdef OP_FETCH_COUNT_EN
        .op_count_out  (op_count_out),
`endif
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    logic [7:0] mem [DEPTH];
    logic [7:0] rd1, rd2;

    always_ff @(posedge clk_in) begin
        rd1 <= mem[bram_addr_out];
        rd2 <= rd1;
    end
    assign bram_data_in = rd2;

    int total = 0;
    int bad   = 0;
    int exp_op[$];
    int exp_pc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected stream: walk memory from the start address (wrapping) until the first HALT.
    task automatic build_expected(input int saddr);
        int pc;
        exp_op.delete();
        exp_pc.delete();
        pc = saddr;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem[pc] == 8'hFF) break;
            exp_op.push_back(int'(mem[pc]));
            exp_pc.push_back(pc);
            pc = (pc + 1) % DEPTH;
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run_prog(input string tag, input int saddr, input int stall, input int pct,
                            input bit poke_start);
        int  n, first_v, first_x, last_x, done_cnt, done_cyc, xfers;
        bit  prev_stall;
        logic [7:0] prev_op;
        build_expected(saddr);
        n = exp_op.size();
        first_v = -1; first_x = -1; last_x = -1;
        done_cnt = 0; done_cyc = -1; xfers = 0; prev_stall = 1'b0; prev_op = 8'h00;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            start_in      = (cyc == 0) || (poke_start && cyc == 2);
            start_addr_in = (cyc == 0) ? 10'(saddr) : 10'((saddr + 100) % DEPTH);
            op_ready_in   = (cyc < stall) ? 1'b0 : ($urandom_range(99) < pct);
            @(negedge clk_in);
`ifdef OP_FETCH_COUNT_EN
            if (cyc == 1) chk({tag, " count_cleared"}, 32'(op_count_out), 32'd0);
`endif
            if (prev_stall) begin
                chk({tag, " stall_valid"}, 32'(op_valid_out), 32'd1);
                chk({tag, " stall_op"}, 32'(op_out), 32'(prev_op));
            end
            if (op_valid_out && first_v < 0) first_v = cyc;
            if (op_valid_out && op_ready_in) begin
                if (exp_op.size() == 0) begin
                    chk({tag, " extra_op"}, 32'(op_out), 32'hFFFF_FFFF);
                end else begin
                    chk({tag, " op"}, 32'(op_out), 32'(exp_op.pop_front()));
                    chk({tag, " pc"}, 32'(op_pc_out), 32'(exp_pc.pop_front()));
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                xfers++;
            end
            prev_stall = op_valid_out && !op_ready_in;
            prev_op    = op_out;
            if (done_out) begin
                done_cnt++;
                chk({tag, " done_after_all"}, 32'(exp_op.size()), 32'd0);
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk_in);
            #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start_in    = 1'b0;
        op_ready_in = 1'b0;
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " transfers"}, 32'(xfers), 32'(n));
        if (n > 0) chk({tag, " first_valid_cycle"}, 32'(first_v), 32'd4);
        if (n > 0 && stall == 0 && pct == 100)
            chk({tag, " throughput"}, 32'(last_x - first_x), 32'(n - 1));
        @(negedge clk_in);
        chk({tag, " idle_busy"}, 32'(busy_out), 32'd0);
`ifdef OP_FETCH_COUNT_EN
        chk({tag, " count"}, 32'(op_count_out), 32'(n));
`endif
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_prog1();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;
    endtask

    initial begin
        int sa, len;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        rst_in = 1'b1; start_in = 1'b0; start_addr_in = 10'd0; abort_in = 1'b0; op_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("rst valid", 32'(op_valid_out), 32'd0);
        chk("rst op", 32'(op_out), 32'd0);
        chk("rst pc", 32'(op_pc_out), 32'd0);
        chk("rst busy", 32'(busy_out), 32'd0);
        chk("rst done", 32'(done_out), 32'd0);
        chk("rst addr", 32'(bram_addr_out), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        load_prog1();
        run_prog("basic", 0, 0, 100, 1'b0);
        run_prog("stall20", 0, 20, 100, 1'b0);

        mem[1022] = 8'h11; mem[1023] = 8'h22; mem[0] = 8'h33; mem[1] = 8'hFF;
        run_prog("wrap", 1022, 0, 100, 1'b0);
        load_prog1();

        for (int i = 0; i < 10; i++) mem[200 + i] = 8'(8'h40 + i);
        mem[210] = 8'hFF;
        run_prog("start_in_run", 200, 0, 100, 1'b1);
        run_prog("count_again", 200, 0, 70, 1'b0);

        // Abort with ready held low so the FIFO is full of ops.
        for (int i = 0; i < 20; i++) mem[100 + i] = 8'(i + 1);
        mem[120] = 8'hFF;
        start_in = 1'b1; start_addr_in = 10'd100; op_ready_in = 1'b0;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        repeat (8) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("abort pre_valid", 32'(op_valid_out), 32'd1);
        chk("abort pre_op", 32'(op_out), 32'h01);
        chk("abort pre_busy", 32'(busy_out), 32'd1);
        @(posedge clk_in);
        #1;
        abort_in = 1'b1;
        @(negedge clk_in);
        chk("abort cycle_done", 32'(done_out), 32'd0);
        @(posedge clk_in);
        #1;
        abort_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            chk("abort valid", 32'(op_valid_out), 32'd0);
            chk("abort busy", 32'(busy_out), 32'd0);
            chk("abort done", 32'(done_out), 32'd0);
            @(posedge clk_in);
            #1;
        end
        run_prog("after_abort", 0, 0, 100, 1'b0);

        // start and abort together in IDLE: nothing happens.
        start_in = 1'b1; abort_in = 1'b1; start_addr_in = 10'd0;
        @(posedge clk_in);
        #1;
        start_in = 1'b0; abort_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            chk("start_abort busy", 32'(busy_out), 32'd0);
            chk("start_abort valid", 32'(op_valid_out), 32'd0);
            @(posedge clk_in);
            #1;
        end

        for (int r = 0; r < 6; r++) begin
            sa  = $urandom_range(DEPTH - 1);
            len = $urandom_range(25, 1);
            for (int k = 0; k < len; k++) mem[(sa + k) % DEPTH] = 8'($urandom_range(254));
            mem[(sa + len) % DEPTH] = 8'hFF;
            run_prog("random", sa, (r == 2) ? 7 : 0, (r == 0) ? 100 : 55, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
